hazard_fwd_ctrl: RTL and testbench

//  Pipeline hazard and forwarding controller for the 5-stage RV32I core.

---
 rtl/hazard_fwd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: EX operand
// forwarding selects, load-use stalls, branch flushes and MUL/DIV wait sequencing.
//
// state    | meaning
// ST_RUN   | normal issue; forwarding, load-use and branch handling active
// ST_MDU_WAIT | EX frozen on a multi-cycle MUL/DIV, waiting for mdu_done_i
module hazard_fwd_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_mdu_op_i,
  input  logic             ex_branch_tkn_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  input  logic             mdu_done_i,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             mdu_start_o,
  output logic             mdu_err_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int TW = $clog2(MDU_TIMEOUT) + 1;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             mdu_err_q, mdu_err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             load_use;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_start;

  always_comb begin
    fwd_a = 2'b00;
    if (mem_reg_write_i && mem_rd_i != 5'd0 && mem_rd_i == ex_rs1_i)
      fwd_a = 2'b10;
    else if (wb_reg_write_i && wb_rd_i != 5'd0 && wb_rd_i == ex_rs1_i)
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (mem_reg_write_i && mem_rd_i != 5'd0 && mem_rd_i == ex_rs2_i)
      fwd_b = 2'b10;
    else if (wb_reg_write_i && wb_rd_i != 5'd0 && wb_rd_i == ex_rs2_i)
      fwd_b = 2'b01;
  end

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && id_rs1_i == ex_rd_i) ||
                     (id_use_rs2_i && id_rs2_i == ex_rd_i));

  assign cnt_inc = cnt_q + TW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_err_d = mdu_err_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    mdu_start = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (ex_mdu_op_i) begin
          mdu_start = 1'b1;
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          state_d   = ST_MDU_WAIT;
        end else if (ex_branch_tkn_i) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        if (mdu_done_i) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          // Give up once the counter would reach MDU_TIMEOUT-1; the abort is sticky.
          if (cnt_inc == TW'(MDU_TIMEOUT - 1)) begin
            mdu_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_RUN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (rst_i) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      mdu_start = 1'b0;
    end
  end

  assign stall_count_d = stall_if ? stall_count_q + CNT_W'(1) : stall_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      mdu_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mdu_err_q     <= mdu_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a_sel_o   = rst_i ? 2'b00 : fwd_a;
  assign fwd_b_sel_o   = rst_i ? 2'b00 : fwd_b;
  assign stall_if_o    = stall_if;
  assign stall_id_o    = stall_id;
  assign stall_ex_o    = stall_ex;
  assign flush_id_o    = flush_id;
  assign flush_ex_o    = flush_ex;
  assign mdu_start_o   = mdu_start;
  assign mdu_err_o     = mdu_err_q & ~rst_i;
  assign stall_count_o = rst_i ? '0 : stall_count_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding priority, load-use, branch
// flush, MDU wait/done, MDU timeout and reset during MDU_WAIT.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_mdu_op, ex_branch_tkn;
  logic        mem_reg_write, wb_reg_write, mdu_done;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_start, mdu_err;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;
  int stalls;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.MDU_TIMEOUT(8), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
    .ex_mem_read_i(ex_mem_read), .ex_mdu_op_i(ex_mdu_op),
    .ex_branch_tkn_i(ex_branch_tkn),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write),
    .mdu_done_i(mdu_done),
    .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .mdu_start_o(mdu_start), .mdu_err_o(mdu_err),
    .stall_count_o(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_mdu_op = 0;
    ex_branch_tkn = 0; mem_rd = 0; mem_reg_write = 0; wb_rd = 0;
    wb_reg_write = 0; mdu_done = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Inputs that would otherwise forward and start the MDU must be masked in reset.
    mem_reg_write = 1; mem_rd = 5; ex_rs1 = 5; ex_mdu_op = 1;
    #1;
    check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    check("rst_stall_if", 32'(stall_if), 32'd0);
    check("rst_mdu_start", 32'(mdu_start), 32'd0);
    tick(); tick();
    check("rst_stall_count", stall_count, 32'd0);
    check("rst_mdu_err", 32'(mdu_err), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    mem_reg_write = 1; mem_rd = 5; wb_reg_write = 1; wb_rd = 5; ex_rs1 = 5;
    #1 check("fwd_a_mem_over_wb", 32'(fwd_a_sel), 32'd2);
    ex_rs1 = 0;
    #1 check("fwd_a_x0", 32'(fwd_a_sel), 32'd0);
    ex_rs1 = 5; mem_reg_write = 0;
    #1 check("fwd_a_wb", 32'(fwd_a_sel), 32'd1);
    mem_reg_write = 1; mem_rd = 3; wb_rd = 4; ex_rs2 = 4;
    #1 check("fwd_b_wb", 32'(fwd_b_sel), 32'd1);
    ex_rs2 = 3;
    #1 check("fwd_b_mem", 32'(fwd_b_sel), 32'd2);
    wb_reg_write = 0; ex_rs2 = 4;
    #1 check("fwd_b_none", 32'(fwd_b_sel), 32'd0);
    clear_inputs();
    tick();

    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    #1;
    check("lu_stall_if", 32'(stall_if), 32'd1);
    check("lu_stall_id", 32'(stall_id), 32'd1);
    check("lu_flush_ex", 32'(flush_ex), 32'd1);
    check("lu_stall_ex", 32'(stall_ex), 32'd0);
    check("lu_flush_id", 32'(flush_id), 32'd0);
    tick();
    clear_inputs();
    mem_rd = 7; mem_reg_write = 1; ex_rs2 = 7;
    #1;
    check("lu_next_stall_if", 32'(stall_if), 32'd0);
    check("lu_next_fwd_b", 32'(fwd_b_sel), 32'd2);
    check("lu_stall_count", stall_count, 32'd1);
    clear_inputs();

    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
    #1 check("lu_unused_rs2", 32'(stall_if), 32'd0);
    id_use_rs2 = 1; ex_rd = 0; id_rs2 = 0;
    #1 check("lu_rd_x0", 32'(stall_if), 32'd0);
    ex_rd = 7; id_rs2 = 7; ex_branch_tkn = 1;
    #1;
    check("br_flush_id", 32'(flush_id), 32'd1);
    check("br_flush_ex", 32'(flush_ex), 32'd1);
    check("br_no_stall", 32'(stall_if), 32'd0);
    tick();
    clear_inputs();
    #1 check("br_stall_count", stall_count, 32'd1);

    ex_mdu_op = 1;
    #1;
    check("mdu_start", 32'(mdu_start), 32'd1);
    stalls = stall_ex ? 1 : 0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      ex_branch_tkn = (i == 2);
      #1;
      check("mdu_wait_no_start", 32'(mdu_start), 32'd0);
      if (i == 2) check("mdu_wait_br_ignored", 32'(flush_id), 32'd0);
      if (stall_ex) stalls++;
      tick();
    end
    ex_branch_tkn = 0;
    mdu_done = 1;
    #1;
    check("mdu_done_stall_ex", 32'(stall_ex), 32'd0);
    check("mdu_done_stall_if", 32'(stall_if), 32'd0);
    check("mdu_stall_ex_cycles", 32'(stalls), 32'd6);
    tick();
    clear_inputs();
    ex_branch_tkn = 1;
    #1 check("mdu_back_in_run", 32'(flush_id), 32'd1);
    check("mdu_stall_count", stall_count, 32'd7);
    clear_inputs();
    tick();

    ex_mdu_op = 1;
    #1 stalls = stall_if ? 1 : 0;
    tick();
    ex_mdu_op = 0;
    #1 check("to_err_low_early", 32'(mdu_err), 32'd0);
    begin
      int guard = 0;
      while (stall_if && guard < 20) begin
        stalls++;
        tick();
        #1;
        guard++;
      end
      check("to_bounded", 32'(guard < 20), 32'd1);
    end
    check("to_stall_cycles", 32'(stalls), 32'd8);
    check("to_mdu_err", 32'(mdu_err), 32'd1);
    check("to_stall_count", stall_count, 32'd15);
    tick(); tick(); tick();
    check("to_err_sticky", 32'(mdu_err), 32'd1);

    ex_mdu_op = 1;
    #1;
    tick();
    ex_mdu_op = 0;
    tick();
    #1 check("rw_waiting", 32'(stall_ex), 32'd1);
    rst = 1'b1;
    #1 check("rw_rst_comb_stall", 32'(stall_if), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rw_stall_ex", 32'(stall_ex), 32'd0);
    check("rw_mdu_start", 32'(mdu_start), 32'd0);
    check("rw_mdu_err_cleared", 32'(mdu_err), 32'd0);
    check("rw_stall_count", stall_count, 32'd0);
    ex_branch_tkn = 1;
    #1 check("rw_run_branch", 32'(flush_id), 32'd1);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
